channel_micropipe: RTL and testbench

CHANNEL_MICROPIPE -- requirements
Module: channel_micropipe

---
 rtl/channel_micropipe_pkg.sv | 19 +
 rtl/channel_micropipe_fifo.sv | 54 +++++
 rtl/channel_micropipe.sv | 110 +++++++++++
 tb/tb_channel_micropipe.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_micropipe_pkg.sv
// Shared types for the channel micropipe: handshake FSM state encodings.
package channel_micropipe_pkg;

  // Upstream (receiving) side: waiting for a request, or holding ack high
  // until the sender withdraws its request.
  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_HOLD = 1'b1
  } in_state_t;

  // Downstream (sending) side: idle, request raised, or waiting for the
  // receiver to drop its acknowledge before the next packet may start.
  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_REQ  = 2'd1,
    OUT_WAIT = 2'd2
  } out_state_t;

endpackage

// File: rtl/channel_micropipe_fifo.sv
// Circular packet buffer between the two handshake sides. DEPTH must be a
// power of two so the pointers wrap naturally at their bit width.
module channel_micropipe_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Guard against overflow/underflow even if a caller misbehaves.
  assign full  = (count == CNT_W'(DEPTH));
  assign wr_en = push && !full;
  assign rd_en = pop && (count != '0);
  assign head  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Packet storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/channel_micropipe.sv
// Four-phase to four-phase micropipeline stage with a small FIFO between the
// upstream and downstream handshakes. All inputs are treated as synchronous
// to clk.
module channel_micropipe
  import channel_micropipe_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_req,
  output logic                       in_ack,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_req,
  input  logic                       out_ack,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  in_state_t        in_state;
  out_state_t       out_state;
  logic             push;
  logic             pop;
  logic             full;
  logic [WIDTH-1:0] head;

  // A push happens only on the first cycle a request is seen with room in the
  // buffer; a request still held high in IN_HOLD never pushes again.
  assign push = (in_state == IN_IDLE) && in_req && !full;

  // The head is consumed when the receiver acknowledges the raised request.
  assign pop  = (out_state == OUT_REQ) && out_ack;

  channel_micropipe_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .count     (count)
  );

  // Upstream handshake: ack the accepted packet, hold until req withdraws.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_state <= IN_IDLE;
      in_ack   <= 1'b0;
    end else begin
      case (in_state)
        IN_IDLE: begin
          if (push) begin
            in_ack   <= 1'b1;
            in_state <= IN_HOLD;
          end
        end
        IN_HOLD: begin
          if (!in_req) begin
            in_ack   <= 1'b0;
            in_state <= IN_IDLE;
          end
        end
        default: begin
          in_ack   <= 1'b0;
          in_state <= IN_IDLE;
        end
      endcase
    end
  end

  // Downstream handshake: present the head, pop on ack, wait for ack to fall.
  // out_data is only reloaded from OUT_IDLE, so it stays stable through the
  // whole request and the trailing acknowledge phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_state <= OUT_IDLE;
      out_req   <= 1'b0;
      out_data  <= '0;
    end else begin
      case (out_state)
        OUT_IDLE: begin
          if (count != '0) begin
            out_data  <= head;
            out_req   <= 1'b1;
            out_state <= OUT_REQ;
          end
        end
        OUT_REQ: begin
          if (out_ack) begin
            out_req   <= 1'b0;
            out_state <= OUT_WAIT;
          end
        end
        OUT_WAIT: begin
          if (!out_ack) out_state <= OUT_IDLE;
        end
        default: begin
          out_req   <= 1'b0;
          out_state <= OUT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_micropipe.sv
// Self-checking bench for channel_micropipe (WIDTH=12, DEPTH=2).
module tb_channel_micropipe;

  localparam int WIDTH = 12;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_req;
  logic             in_ack;
  logic [WIDTH-1:0] in_data;
  logic             out_req;
  logic             out_ack;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  logic             resp_en  = 1'b0;
  logic             resp_ack = 1'b0;
  logic             man_ack  = 1'b0;

  int checks    = 0;
  int failures  = 0;
  int acc       = 0;   // packets the reference model saw accepted
  int popd      = 0;   // packets the reference model saw consumed
  int delivered = 0;   // out_req rising edges observed
  int sent      = 0;   // upstream handshakes completed by the driver
  logic [WIDTH-1:0] exp_q[$];

  assign out_ack = resp_en ? resp_ack : man_ack;

  channel_micropipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_req   (in_req),
    .in_ack   (in_ack),
    .in_data  (in_data),
    .out_req  (out_req),
    .out_ack  (out_ack),
    .out_data (out_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: every completed upstream acceptance enqueues the packet,
  // every new downstream request must present the oldest outstanding packet,
  // and occupancy equals accepted minus consumed. Reset discards everything.
  initial begin : monitor
    logic prev_in_ack;
    logic prev_out_req;
    prev_in_ack  = 1'b0;
    prev_out_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        exp_q.delete();
        acc  = 0;
        popd = 0;
      end else begin
        if (in_ack && !prev_in_ack) begin
          exp_q.push_back(in_data);
          acc++;
        end
        if (!out_req && prev_out_req) popd++;
        if (out_req && !prev_out_req) begin
          delivered++;
          check("pkt_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) check("fifo_order", 32'(out_data), 32'(exp_q.pop_front()));
        end
        check("count_model", 32'(count), 32'(acc - popd));
      end
      prev_in_ack  = in_ack;
      prev_out_req = out_req;
    end
  end

  // Downstream responder with random acknowledge timing.
  initial begin : responder
    forever begin
      @(negedge clk);
      if (resp_en && out_req && !resp_ack) begin
        int n;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        resp_ack = 1'b1;
        n = 0;
        while (out_req && n < 200) begin
          @(negedge clk);
          n++;
        end
        check("resp_req_fall_timeout", 32'(n < 200), 32'd1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        resp_ack = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // One complete upstream four-phase transfer, starting at a negedge.
  task automatic send(input logic [WIDTH-1:0] d, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    in_data = d;
    in_req  = 1'b1;
    n = 0;
    while (!in_ack && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("send_ack_timeout", 32'(n < 500), 32'd1);
    in_req = 1'b0;
    n = 0;
    while (in_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_release_timeout", 32'(n < 50), 32'd1);
    sent++;
  endtask

  // Let the responder empty the buffer and finish its last handshake.
  task automatic drain();
    int n;
    resp_en = 1'b1;
    n = 0;
    while (!(count == '0 && !out_req && !out_ack) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 3000), 32'd1);
    @(negedge clk);
    @(negedge clk);
    resp_en = 1'b0;
  endtask

  typedef struct {
    logic             in_req;
    logic [WIDTH-1:0] in_data;
    logic             out_ack;
    logic             exp_in_ack;
    logic             exp_out_req;
    logic [CW-1:0]    exp_count;
    logic [WIDTH-1:0] exp_out_data;
  } vec_t;

  vec_t tbl[9];

  initial begin : main
    int s0;
    int t0;
    int n;

    // Cycle-accurate vectors: first push, one-cycle latency, then a push and
    // pop landing on the same edge with one packet buffered.
    tbl[0] = '{1'b1, 12'h14D, 1'b0, 1'b1, 1'b0, 2'd1, 12'h000};
    tbl[1] = '{1'b1, 12'h14D, 1'b0, 1'b1, 1'b1, 2'd1, 12'h14D};
    tbl[2] = '{1'b0, 12'h14D, 1'b0, 1'b0, 1'b1, 2'd1, 12'h14D};
    tbl[3] = '{1'b1, 12'h04D, 1'b1, 1'b1, 1'b0, 2'd1, 12'h14D};
    tbl[4] = '{1'b0, 12'h04D, 1'b0, 1'b0, 1'b0, 2'd1, 12'h14D};
    tbl[5] = '{1'b0, 12'h04D, 1'b0, 1'b0, 1'b1, 2'd1, 12'h04D};
    tbl[6] = '{1'b0, 12'h04D, 1'b1, 1'b0, 1'b0, 2'd0, 12'h04D};
    tbl[7] = '{1'b0, 12'h04D, 1'b0, 1'b0, 1'b0, 2'd0, 12'h04D};
    tbl[8] = '{1'b0, 12'h04D, 1'b0, 1'b0, 1'b0, 2'd0, 12'h04D};

    rst_n   = 1'b0;
    in_req  = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ack", 32'(in_ack), 32'd0);
    check("rst_out_req", 32'(out_req), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_req  = tbl[i].in_req;
      in_data = tbl[i].in_data;
      man_ack = tbl[i].out_ack;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_in_ack", i), 32'(in_ack), 32'(tbl[i].exp_in_ack));
      check($sformatf("vec%0d_out_req", i), 32'(out_req), 32'(tbl[i].exp_out_req));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
      check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].exp_out_data));
    end
    @(negedge clk);
    in_req  = 1'b0;
    man_ack = 1'b0;

    // Request held high for 20 cycles: a single push, ack held throughout.
    @(negedge clk);
    s0      = delivered;
    in_data = 12'h2A5;
    in_req  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("hold_in_ack", 32'(in_ack), 32'd1);
      check("hold_count", 32'(count), 32'd1);
    end
    @(negedge clk);
    in_req = 1'b0;
    @(posedge clk);
    #1;
    check("hold_release", 32'(in_ack), 32'd0);
    @(negedge clk);
    drain();
    check("hold_single", 32'(delivered - s0), 32'd1);
    check("hold_queue_empty", 32'(exp_q.size()), 32'd0);

    // Ordered delivery with random gaps, then a random soak.
    s0 = delivered;
    t0 = sent;
    resp_en = 1'b1;
    send(12'h04D, $urandom_range(0, 9));
    send(12'h11B, $urandom_range(0, 9));
    send(12'h008, $urandom_range(0, 9));
    for (int i = 0; i < 40; i++) send(WIDTH'($urandom), $urandom_range(0, 9));
    drain();
    check("rand_all_delivered", 32'(delivered - s0), 32'(sent - t0));
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: two accepted, third waits until one output handshake.
    resp_en = 1'b0;
    man_ack = 1'b0;
    send(12'h3C1, 0);
    send(12'h0F2, 0);
    in_data = 12'h7E4;
    in_req  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_in_ack_low", 32'(in_ack), 32'd0);
    end
    check("bp_count_full", 32'(count), 32'd2);
    check("bp_out_req", 32'(out_req), 32'd1);
    @(negedge clk);
    man_ack = 1'b1;
    n = 0;
    while (out_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_pop_timeout", 32'(n < 20), 32'd1);
    man_ack = 1'b0;
    n = 0;
    while (!in_ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("bp_third_accepted", 32'(in_ack), 32'd1);
    in_req = 1'b0;
    drain();
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset with a full buffer mid-handshake, request still high afterwards.
    send(12'h155, 0);
    send(12'h2AA, 0);
    check("mrst_pre_out_req", 32'(out_req), 32'd1);
    check("mrst_pre_count", 32'(count), 32'd2);
    in_data = 12'h3F0;
    in_req  = 1'b1;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    s0 = delivered;
    check("mrst_out_req", 32'(out_req), 32'd0);
    check("mrst_in_ack", 32'(in_ack), 32'd0);
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!in_ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("mrst_new_accept", 32'(in_ack), 32'd1);
    in_req = 1'b0;
    drain();
    check("mrst_single_delivery", 32'(delivered - s0), 32'd1);
    check("mrst_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
